// File: rtl/cond_unit_mc.sv
// NZCV flag register and ARM condition evaluation for the execute stage, with support for
// multi-cycle flag sources that hold issue until their result is valid or a timeout expires.
module cond_unit_mc #(
  parameter int unsigned NSRC     = 2,
  parameter int unsigned SW       = 1,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue,
  input  logic [3:0]           Cond,
  input  logic [1:0]           FlagW,
  input  logic [SW-1:0]        FlagSrc,
  input  logic                 MultiCyc,
  input  logic                 PCS,
  input  logic                 RegW,
  input  logic                 MemW,
  input  logic [4*NSRC-1:0]    SrcFlags,
  input  logic [NSRC-1:0]      SrcValid,
  output logic                 CondEx,
  output logic                 PCSrc,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic                 Stall,
  output logic [3:0]           Flags,
  output logic                 Timeout
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  typedef enum logic {StIdle, StWait} state_e;

  state_e          state_q;
  logic [3:0]      flags_q;
  logic            timeout_q;
  logic            h_cond_q, h_pcs_q, h_regw_q, h_memw_q;
  logic [1:0]      h_flagw_q;
  logic [SW-1:0]   h_src_q;
  logic [CW-1:0]   cnt_q;

  logic            pass;
  logic            held_valid;
  logic            fire;
  logic            single;
  logic [SW-1:0]   sel;
  logic [3:0]      sel_flags;
  logic [3:0]      held_flags;

  // Odd codes invert the even code's base condition; 111x is always true.
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    {n, z, cf, v} = f;
    unique case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cf;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cf & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return (c[3:1] == 3'd7) ? 1'b1 : (base ^ c[0]);
  endfunction

  // Out-of-range selectors fall back to source 0.
  always_comb begin
    sel        = '0;
    sel_flags  = '0;
    held_flags = '0;
    held_valid = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (FlagSrc == SW'(i)) sel = SW'(i);
    end
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (sel == SW'(i)) sel_flags = SrcFlags[4*i +: 4];
      if (h_src_q == SW'(i)) begin
        held_flags = SrcFlags[4*i +: 4];
        held_valid = SrcValid[i];
      end
    end
  end

  assign pass   = cond_pass(Cond, flags_q);
  assign fire   = held_valid & h_cond_q;
  assign single = issue & ~MultiCyc & pass;

  // Enables are forced low while reset is held, even though they are combinational.
  always_comb begin
    CondEx   = 1'b0;
    PCSrc    = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    Stall    = 1'b0;
    if (reset) begin
      unique case (state_q)
        StIdle: begin
          CondEx   = issue & pass;
          PCSrc    = PCS & single;
          RegWrite = RegW & single;
          MemWrite = MemW & single;
        end
        StWait: begin
          CondEx   = h_cond_q;
          PCSrc    = h_pcs_q & fire;
          RegWrite = h_regw_q & fire;
          MemWrite = h_memw_q & fire;
          Stall    = 1'b1;
        end
      endcase
    end
  end

  assign Flags   = flags_q;
  assign Timeout = timeout_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      flags_q   <= '0;
      timeout_q <= 1'b0;
      h_cond_q  <= 1'b0;
      h_pcs_q   <= 1'b0;
      h_regw_q  <= 1'b0;
      h_memw_q  <= 1'b0;
      h_flagw_q <= '0;
      h_src_q   <= '0;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (issue && !MultiCyc) begin
            if (pass && FlagW[1]) flags_q[3:2] <= sel_flags[3:2];
            if (pass && FlagW[0]) flags_q[1:0] <= sel_flags[1:0];
          end else if (issue) begin
            h_cond_q  <= pass;
            h_pcs_q   <= PCS;
            h_regw_q  <= RegW;
            h_memw_q  <= MemW;
            h_flagw_q <= FlagW;
            h_src_q   <= sel;
            cnt_q     <= '0;
            state_q   <= StWait;
          end
        end
        StWait: begin
          if (held_valid) begin
            if (h_cond_q && h_flagw_q[1]) flags_q[3:2] <= held_flags[3:2];
            if (h_cond_q && h_flagw_q[0]) flags_q[1:0] <= held_flags[1:0];
            state_q <= StIdle;
          end else if (cnt_q == CW'(MAX_WAIT - 1)) begin
            timeout_q <= 1'b1;
            state_q   <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cond_unit_mc.sv
// Bench for cond_unit_mc: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a transaction-level model of the flag unit.
module tb_cond_unit_mc;

  localparam int NSRC     = 2;
  localparam int SW       = 1;
  localparam int MAX_WAIT = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic              issue;
  logic [3:0]        Cond;
  logic [1:0]        FlagW;
  logic [SW-1:0]     FlagSrc;
  logic              MultiCyc, PCS, RegW, MemW;
  logic [4*NSRC-1:0] SrcFlags;
  logic [NSRC-1:0]   SrcValid;
  logic              CondEx, PCSrc, RegWrite, MemWrite, Stall, Timeout;
  logic [3:0]        Flags;

  int n_total = 0;
  int n_pass  = 0;

  // Model state: committed flags, sticky timeout, and the pending long-latency instruction.
  logic [3:0] m_flags;
  bit         m_timeout;
  bit         m_wait;
  int         m_waited;
  bit         h_pass, h_pcs, h_regw, h_memw;
  bit [1:0]   h_flagw;
  int         h_src;

  cond_unit_mc #(.NSRC(NSRC), .SW(SW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .issue(issue), .Cond(Cond), .FlagW(FlagW), .FlagSrc(FlagSrc),
    .MultiCyc(MultiCyc), .PCS(PCS), .RegW(RegW), .MemW(MemW), .SrcFlags(SrcFlags),
    .SrcValid(SrcValid), .CondEx(CondEx), .PCSrc(PCSrc), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .Stall(Stall), .Flags(Flags), .Timeout(Timeout)
  );

  always #5 clk = ~clk;

  function automatic bit condtab(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c)
      4'd0:    return z;
      4'd1:    return !z;
      4'd2:    return cf;
      4'd3:    return !cf;
      4'd4:    return n;
      4'd5:    return !n;
      4'd6:    return v;
      4'd7:    return !v;
      4'd8:    return cf && !z;
      4'd9:    return !cf || z;
      4'd10:   return n == v;
      4'd11:   return n != v;
      4'd12:   return !z && (n == v);
      4'd13:   return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  function automatic int srcidx(input int fs);
    return (fs >= NSRC) ? 0 : fs;
  endfunction

  function automatic logic [3:0] merge(input logic [3:0] old, input logic [3:0] nw,
                                       input bit [1:0] w);
    logic [3:0] r;
    r = old;
    if (w[1]) r[3:2] = nw[3:2];
    if (w[0]) r[1:0] = nw[1:0];
    return r;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
  endtask

  task automatic model_clear();
    m_flags = '0; m_timeout = 0; m_wait = 0; m_waited = 0;
    h_pass = 0; h_pcs = 0; h_regw = 0; h_memw = 0; h_flagw = '0; h_src = 0;
  endtask

  task automatic idle_inputs();
    issue = 0; Cond = 4'd0; FlagW = '0; FlagSrc = '0; MultiCyc = 0;
    PCS = 0; RegW = 0; MemW = 0; SrcFlags = '0; SrcValid = '0;
  endtask

  // Called at a negedge with inputs applied: compare all outputs, then advance the model.
  task automatic tick();
    logic e_cx, e_pc, e_rw, e_mw, e_st, e_to;
    logic [3:0] e_fl;
    bit pass, go, v;
    int s;
    #1;
    {e_cx, e_pc, e_rw, e_mw, e_st, e_to} = '0;
    e_fl = '0;
    if (reset) begin
      e_fl = m_flags;
      e_to = m_timeout;
      if (!m_wait) begin
        pass = condtab(Cond, m_flags);
        go   = issue && !MultiCyc && pass;
        e_cx = issue && pass;
        e_pc = PCS && go;
        e_rw = RegW && go;
        e_mw = MemW && go;
      end else begin
        v    = SrcValid[h_src] && h_pass;
        e_cx = h_pass;
        e_st = 1'b1;
        e_pc = h_pcs && v;
        e_rw = h_regw && v;
        e_mw = h_memw && v;
      end
    end
    chk("CondEx", CondEx, e_cx);
    chk("PCSrc", PCSrc, e_pc);
    chk("RegWrite", RegWrite, e_rw);
    chk("MemWrite", MemWrite, e_mw);
    chk("Stall", Stall, e_st);
    chk("Flags", Flags, e_fl);
    chk("Timeout", Timeout, e_to);
    @(posedge clk);
    if (!reset) begin
      model_clear();
    end else if (!m_wait) begin
      pass = condtab(Cond, m_flags);
      s    = srcidx(int'(FlagSrc));
      if (issue && !MultiCyc && pass) m_flags = merge(m_flags, SrcFlags[4*s +: 4], FlagW);
      if (issue && MultiCyc) begin
        h_pass = pass; h_pcs = PCS; h_regw = RegW; h_memw = MemW;
        h_flagw = FlagW; h_src = s; m_waited = 0; m_wait = 1;
      end
    end else begin
      m_waited++;
      if (SrcValid[h_src]) begin
        if (h_pass) m_flags = merge(m_flags, SrcFlags[4*h_src +: 4], h_flagw);
        m_wait = 0;
      end else if (m_waited == MAX_WAIT) begin
        m_timeout = 1;
        m_wait = 0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int rst_left;
    int vprob;
    reset = 0;
    idle_inputs();
    model_clear();
    @(negedge clk);
    Cond = 4'b1110; issue = 1; RegW = 1;
    tick();
    tick();

    // Reset release, EQ with zero flags fails.
    reset = 1;
    idle_inputs();
    issue = 1; Cond = 4'b0000; RegW = 1;
    #1;
    chk("t1_condex", CondEx, 0);
    chk("t1_regwrite", RegWrite, 0);
    chk("t1_flags", Flags, 4'b0000);
    tick();

    // Single-cycle flag write from source 0, then EQ passes.
    idle_inputs();
    issue = 1; Cond = 4'b1110; FlagW = 2'b11; FlagSrc = 0; SrcFlags = 8'b1111_0100;
    tick();
    idle_inputs();
    issue = 1; Cond = 4'b0000; RegW = 1;
    #1;
    chk("t2_flags", Flags, 4'b0100);
    chk("t2_regwrite", RegWrite, 1);
    tick();

    // Multi-cycle source 1 completes on the third wait cycle, writes N,Z only.
    idle_inputs();
    issue = 1; MultiCyc = 1; FlagSrc = 1; FlagW = 2'b10; Cond = 4'b1110; RegW = 1;
    #1;
    chk("t3_issue_stall", Stall, 0);
    chk("t3_issue_regwrite", RegWrite, 0);
    tick();
    idle_inputs();
    issue = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("t3_wait_stall", Stall, 1);
      chk("t3_wait_regwrite", RegWrite, 0);
      tick();
    end
    SrcValid = 2'b10; SrcFlags = 8'b1001_0000;
    #1;
    chk("t3_done_stall", Stall, 1);
    chk("t3_done_regwrite", RegWrite, 1);
    tick();
    idle_inputs();
    #1;
    chk("t3_after_stall", Stall, 0);
    chk("t3_after_flags", Flags, 4'b1000);
    tick();

    // Multi-cycle with failing condition consumes the result but writes nothing.
    idle_inputs();
    issue = 1; MultiCyc = 1; FlagSrc = 0; FlagW = 2'b11; Cond = 4'b0000;
    RegW = 1; MemW = 1; PCS = 1;
    #1;
    chk("t4_condex", CondEx, 0);
    tick();
    idle_inputs();
    tick();
    tick();
    SrcValid = 2'b01; SrcFlags = 8'b0000_1111;
    #1;
    chk("t4_stall", Stall, 1);
    chk("t4_regwrite", RegWrite, 0);
    chk("t4_memwrite", MemWrite, 0);
    chk("t4_pcsrc", PCSrc, 0);
    tick();
    idle_inputs();
    #1;
    chk("t4_after_stall", Stall, 0);
    chk("t4_after_flags", Flags, 4'b1000);
    tick();

    // Source never responds: timeout after MAX_WAIT wait cycles, sticky.
    idle_inputs();
    issue = 1; MultiCyc = 1; FlagSrc = 1; Cond = 4'b1110; RegW = 1; FlagW = 2'b11;
    tick();
    idle_inputs();
    for (int k = 1; k <= MAX_WAIT; k++) begin
      if (k == MAX_WAIT) begin
        #1;
        chk("t5_last_stall", Stall, 1);
        chk("t5_last_timeout", Timeout, 0);
      end
      tick();
    end
    issue = 1; Cond = 4'b1110; RegW = 1;
    #1;
    chk("t5_timeout", Timeout, 1);
    chk("t5_stall", Stall, 0);
    chk("t5_regwrite", RegWrite, 1);
    chk("t5_flags", Flags, 4'b1000);
    tick();
    idle_inputs();
    tick();
    chk("t5_sticky", Timeout, 1);

    // Reset in the middle of a wait drops the instruction.
    issue = 1; MultiCyc = 1; FlagSrc = 0; Cond = 4'b1110; RegW = 1; MemW = 1; PCS = 1;
    tick();
    idle_inputs();
    tick();
    reset = 0;
    issue = 1; Cond = 4'b1110; RegW = 1; SrcValid = 2'b11;
    #1;
    chk("t6_condex", CondEx, 0);
    chk("t6_regwrite", RegWrite, 0);
    chk("t6_stall", Stall, 0);
    chk("t6_flags", Flags, 4'b0000);
    chk("t6_timeout", Timeout, 0);
    tick();
    reset = 1;
    issue = 0;
    #1;
    chk("t6_rel_stall", Stall, 0);
    chk("t6_rel_regwrite", RegWrite, 0);
    tick();

    // Randomized traffic, with a sparse-valid phase to provoke timeouts.
    rst_left = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      vprob = (cyc < 1500) ? 40 : 7;
      if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) reset = 1;
      end else if ($urandom_range(0, 299) == 0) begin
        reset = 0;
        rst_left = $urandom_range(1, 3);
      end
      issue    = ($urandom_range(0, 3) != 0);
      Cond     = 4'($urandom);
      FlagW    = 2'($urandom);
      FlagSrc  = SW'($urandom);
      MultiCyc = ($urandom_range(0, 2) == 0);
      PCS      = 1'($urandom);
      RegW     = 1'($urandom);
      MemW     = 1'($urandom);
      SrcFlags = (4*NSRC)'($urandom);
      for (int b = 0; b < NSRC; b++) SrcValid[b] = ($urandom_range(0, 99) < vprob);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
